fp_word_serializer: RTL and testbench

FP_WORD_SERIALIZER -- requirements
Module: fp_word_serializer

---
 rtl/fp_word_serializer.sv | 168 ++++++++++++++++
 tb/tb_fp_word_serializer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_word_serializer.sv
// Serialises packed {S, E, F} words from the floating-point converter onto
// an 11-bit UART-style frame: start, 8 data bits LSB first, even parity, stop.
// A 2-entry FIFO decouples the converter from the serial line.
module fp_word_serializer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       S,
  input  logic [2:0] E,
  input  logic [3:0] F,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [15:0] BaudMax = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // FIFO storage and bookkeeping
  logic [7:0] mem_q [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] count_q, count_d;
  logic       push, pop;
  logic [7:0] packed_in;
  logic [7:0] head;

  // Serialiser state
  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic        tx_q, tx_d;

  assign packed_in = {S, E, F};
  assign head      = mem_q[rd_ptr_q];
  // Full check uses registered occupancy only; a pop this cycle does not free a slot early.
  assign in_ready  = (count_q < 2'd2);
  assign push      = in_valid & in_ready;

  // FIFO occupancy next-state; push and pop together leave it unchanged
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= packed_in;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  // Frame sequencing, baud/bit counting and registered tx next value
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (count_q != 2'd0) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = ^head;
          baud_d  = BaudMax;
          bit_d   = 3'd0;
          state_d = StStart;
        end
      end
      default: begin
        if (baud_q != 16'd0) begin
          baud_d = baud_q - 16'd1;
        end else begin
          baud_d = BaudMax;
          unique case (state_q)
            StStart: state_d = StData;
            StData: begin
              // bit_q wraps 7 -> 0 so the next frame starts at index 0
              bit_d = bit_q + 3'd1;
              if (bit_q == 3'd7) begin
                state_d = StParity;
              end else begin
                shift_d = {1'b0, shift_q[7:1]};
              end
            end
            StParity: state_d = StStop;
            StStop: begin
              if (count_q != 2'd0) begin
                // Back-to-back: next start bit follows the stop bit directly
                pop     = 1'b1;
                shift_d = head;
                par_d   = ^head;
                bit_d   = 3'd0;
                state_d = StStart;
              end else begin
                baud_d  = 16'd0;
                state_d = StIdle;
              end
            end
            default: state_d = StIdle;
          endcase
        end
      end
    endcase

    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  // Serialiser registers; tx is registered so the line never glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != StIdle);
  assign frame_done = (state_q == StStop) && (baud_q == 16'd0);

endmodule

// File: tb/tb_fp_word_serializer.sv
// Bench for fp_word_serializer with CLKS_PER_BIT=4: accepted words go into a
// scoreboard queue, a line monitor decodes every frame and pops/compares.
module tb_fp_word_serializer;

  localparam int unsigned C           = 4;
  localparam int unsigned FrameCycles = 11 * C;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       S;
  logic [2:0] E;
  logic [3:0] F;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic       frame_done;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  logic [7:0]  q[$];
  logic [10:0] bits;
  logic [10:0] last_bits;
  bit          in_frame      = 0;
  int unsigned cyc           = 0;
  int unsigned glob          = 0;
  int unsigned last_done     = 0;
  int unsigned frames_rx     = 0;
  bit          expect_contig = 0;

  fp_word_serializer #(
    .CLKS_PER_BIT(C)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .S         (S),
    .E         (E),
    .F         (F),
    .in_ready  (in_ready),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard push on every accepting edge
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n && in_valid && in_ready) q.push_back({S, E, F});
    end
  end

  // Line monitor: decodes frames on the falling edge, checks framing and timing
  initial begin
    int unsigned idx;
    logic [7:0]  data;
    logic [7:0]  exp_b;
    forever begin
      @(negedge clk);
      glob++;
      if (!rst_n) begin
        in_frame = 0;
      end else begin
        if (!in_frame && tx == 1'b0) begin
          in_frame = 1;
          cyc      = 0;
          if (expect_contig) check_eq("contig_gap", glob - last_done, 1);
        end
        check_eq("frame_done", frame_done, (in_frame && cyc == FrameCycles - 1));
        if (in_frame) begin
          idx = cyc / C;
          if (cyc % C == 0) bits[idx] = tx;
          else check_eq("tx_hold", tx, bits[idx]);
          if (cyc == FrameCycles - 1) begin
            data = bits[8:1];
            check_eq("start_bit", bits[0], 1'b0);
            check_eq("stop_bit", bits[10], 1'b1);
            check_eq("parity", bits[9], ^data);
            if (q.size() == 0) begin
              check_eq("unexpected_frame", data, 32'hffff_ffff);
            end else begin
              exp_b = q.pop_front();
              check_eq("byte", data, exp_b);
            end
            last_bits = bits;
            in_frame  = 0;
            last_done = glob;
            frames_rx++;
          end else begin
            cyc++;
          end
        end
      end
    end
  end

  // Offer one word now; holds it until accepted, then withdraws before the next edge
  task automatic send(input logic [7:0] b, output bit ok);
    in_valid  = 1'b1;
    {S, E, F} = b;
    ok        = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk);
      if (in_ready) ok = 1;
    end
    #1;
    in_valid = 1'b0;
    if (!ok) check_eq("send_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || in_frame || q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check_eq("idle_timeout", 0, 1);
  endtask

  initial begin
    bit          ok;
    int unsigned f0;
    int          n;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    {S, E, F} = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_tx", tx, 1'b1);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_frame_done", frame_done, 1'b0);

    // Single word 0xDC, accepted on the first edge after release
    rst_n = 1'b1;
    send(8'hDC, ok);
    check_eq("lat_tx_at_accept", tx, 1'b1);
    check_eq("lat_busy_at_accept", busy, 1'b0);
    check_eq("lat_ready_occ1", in_ready, 1'b1);
    @(posedge clk);
    #1;
    check_eq("lat_tx_fall", tx, 1'b0);
    check_eq("lat_busy", busy, 1'b1);
    wait_idle();
    check_eq("dc_bits", last_bits, 11'b11110111000);
    check_eq("dc_frames", frames_rx, 1);

    // Parity boundary bytes
    @(negedge clk);
    send(8'h00, ok);
    wait_idle();
    check_eq("par_00", last_bits[9], 1'b0);
    @(negedge clk);
    send(8'h01, ok);
    wait_idle();
    check_eq("par_01", last_bits[9], 1'b1);

    // Back-to-back: three words offered continuously, then ignored input while full
    f0 = frames_rx;
    @(negedge clk);
    send(8'h3A, ok);
    @(negedge clk);
    send(8'hC5, ok);
    @(negedge clk);
    send(8'h7E, ok);
    check_eq("full_in_ready", in_ready, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      {S, E, F} = 8'($urandom);
      check_eq("full_hold", in_ready, 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    expect_contig = 1;
    wait_idle();
    expect_contig = 0;
    check_eq("b2b_frames", frames_rx - f0, 3);

    // Push on the same edge the stop bit pops with occupancy 1
    f0 = frames_rx;
    @(negedge clk);
    send(8'h96, ok);
    @(negedge clk);
    send(8'h69, ok);
    n = 0;
    while (!frame_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("collide_reach_stop", frame_done, 1'b1);
    send(8'hB4, ok);
    check_eq("collide_ready", in_ready, 1'b1);
    check_eq("collide_tx_start", tx, 1'b0);
    wait_idle();
    check_eq("collide_frames", frames_rx - f0, 3);

    // Reset during data bit 4 with one word queued
    @(negedge clk);
    send(8'hA5, ok);
    @(negedge clk);
    send(8'h5A, ok);
    n = 0;
    while (!(in_frame && cyc >= 21) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst_reach_bit4", in_frame, 1'b1);
    f0 = frames_rx;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_tx", tx, 1'b1);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_in_ready", in_ready, 1'b1);
    check_eq("abort_frame_done", frame_done, 1'b0);
    q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check_eq("post_rst_frames", frames_rx, f0);
    check_eq("post_rst_busy", busy, 1'b0);
    check_eq("post_rst_tx", tx, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
    $fatal(1);
  end

endmodule
